// File: rtl/tpg_pkg.sv
// tpg_pkg: shared types and constants for the test-pattern generator.
//   pat_e        pattern encodings (bars, checker, gradient, bouncing box)
//   COL_*        12-bit RGB 4:4:4 colour constants
//   BAR_COLORS   colour table for the eight vertical bars, left to right
//   *_DEF        default visible-area dimensions
package tpg_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_BOX   = 2'd3
  } pat_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;
  localparam logic [11:0] COL_BOX_FG = 12'hF80;
  localparam logic [11:0] COL_BOX_BG = 12'h008;

  localparam logic [11:0] BAR_COLORS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

endpackage

// File: rtl/tpg_box_mover.sv
// tpg_box_mover: bouncing-box position and direction.
//   clk_i    pixel clock
//   reset_i  synchronous active-high reset (box to (0,0), moving +x/+y)
//   step_i   one-cycle pulse, moves the box one pixel diagonally
//   bx_o     box left column, 0 .. H_ACTIVE-BOX_SIZE
//   by_o     box top row,     0 .. V_ACTIVE-BOX_SIZE
module tpg_box_mover #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        step_i,
  output logic [10:0] bx_o,
  output logic [9:0]  by_o
);

  localparam logic [10:0] BX_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  BY_MAX = 10'(V_ACTIVE - BOX_SIZE);

  logic [10:0] bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  logic        dx_neg_q, dx_neg_d;
  logic        dy_neg_q, dy_neg_d;

  // On reaching a limit the direction flips and the same update already steps
  // back, so the position never sits on an edge for two frames.
  always_comb begin
    bx_d     = bx_q;
    by_d     = by_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    if (step_i) begin
      if (!dx_neg_q) begin
        if (bx_q == BX_MAX) begin
          dx_neg_d = 1'b1;
          bx_d     = bx_q - 11'd1;
        end else begin
          bx_d = bx_q + 11'd1;
        end
      end else begin
        if (bx_q == 11'd0) begin
          dx_neg_d = 1'b0;
          bx_d     = 11'd1;
        end else begin
          bx_d = bx_q - 11'd1;
        end
      end
      if (!dy_neg_q) begin
        if (by_q == BY_MAX) begin
          dy_neg_d = 1'b1;
          by_d     = by_q - 10'd1;
        end else begin
          by_d = by_q + 10'd1;
        end
      end else begin
        if (by_q == 10'd0) begin
          dy_neg_d = 1'b0;
          by_d     = 10'd1;
        end else begin
          by_d = by_q - 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bx_q     <= '0;
      by_q     <= '0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
    end else begin
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
    end
  end

  assign bx_o = bx_q;
  assign by_o = by_q;

endmodule

// File: rtl/testpattern_gen.sv
// testpattern_gen: pixel-colour source for the VGA core.
//   clk_dot     pixel clock
//   reset       synchronous active-high reset
//   x, y        current pixel column/row from the VGA core
//   vid_active  high in the visible region
//   btn_next    debounced asynchronous level; a rising edge selects the next pattern
//   color       registered RGB {r,g,b} 4:4:4, one cycle after x/y/vid_active
//   pattern_sel current pattern (0 bars, 1 checker, 2 gradient, 3 box)
//   frame_cnt   frames since reset, wrapping
// Build option TPG_AUTOCYCLE_EN: also advance the pattern every AUTO_FRAMES
// frames; a button advance restarts that count.
//
// Pattern FSM
//   state     | meaning
//   PAT_BARS  | eight vertical colour bars
//   PAT_CHECK | black/white checkerboard
//   PAT_GRAD  | x/y gradient, blue follows frame count
//   PAT_BOX   | bouncing orange box on dark blue
module testpattern_gen
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int BOX_SIZE   = 32,
  parameter int CHECK_LOG2 = 5
`ifdef TPG_AUTOCYCLE_EN
  ,
  parameter int AUTO_FRAMES = 120
`endif
) (
  input  logic        clk_dot,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        vid_active,
  input  logic        btn_next,
  output logic [11:0] color,
  output logic [1:0]  pattern_sel,
  output logic [7:0]  frame_cnt
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic        origin, frame_start;
  logic        prev_origin_q;
  logic        btn_s1_q, btn_s2_q, btn_d1_q, btn_rise;
  logic        pending_q;
  logic        btn_adv, advance;
  pat_e        pat_q;
  logic [7:0]  frame_cnt_q;
  logic [11:0] color_q, pix_d;
  logic [10:0] bx;
  logic [9:0]  by;
  logic        in_box;

  assign origin      = (x == 11'd0) && (y == 10'd0);
  assign frame_start = origin && !prev_origin_q;
  assign btn_rise    = btn_s2_q && !btn_d1_q;
  // A rising edge in the frame_start cycle itself counts for that frame.
  assign btn_adv     = frame_start && (pending_q || btn_rise);

`ifdef TPG_AUTOCYCLE_EN
  localparam int AW = $clog2(AUTO_FRAMES + 1);
  logic [AW-1:0] auto_cnt_q;
  logic          auto_hit;

  assign auto_hit = frame_start && (auto_cnt_q == AW'(AUTO_FRAMES - 1));
  assign advance  = btn_adv || auto_hit;

  always_ff @(posedge clk_dot) begin
    if (reset) begin
      auto_cnt_q <= '0;
    end else if (frame_start) begin
      auto_cnt_q <= advance ? '0 : auto_cnt_q + AW'(1);
    end
  end
`else
  assign advance = btn_adv;
`endif

  // Reset as "already at origin" so a reset released at (0,0) does not count a frame.
  always_ff @(posedge clk_dot) begin
    if (reset) begin
      prev_origin_q <= 1'b1;
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      btn_d1_q      <= 1'b0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      prev_origin_q <= origin;
      btn_s1_q      <= btn_next;
      btn_s2_q      <= btn_s1_q;
      btn_d1_q      <= btn_s2_q;
      pending_q     <= frame_start ? 1'b0 : (pending_q || btn_rise);
      if (frame_start) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_dot) begin
    if (reset) begin
      pat_q <= PAT_BARS;
    end else if (advance) begin
      case (pat_q)
        PAT_BARS:  pat_q <= PAT_CHECK;
        PAT_CHECK: pat_q <= PAT_GRAD;
        PAT_GRAD:  pat_q <= PAT_BOX;
        default:   pat_q <= PAT_BARS;
      endcase
    end
  end

  tpg_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk_i   (clk_dot),
    .reset_i (reset),
    .step_i  (frame_start),
    .bx_o    (bx),
    .by_o    (by)
  );

  assign in_box = (x >= bx) && (x < bx + 11'(BOX_SIZE)) &&
                  (y >= by) && (y < by + 10'(BOX_SIZE));

  always_comb begin
    pix_d = COL_BLACK;
    case (pat_q)
      PAT_BARS: begin
        for (int i = 0; i < 8; i++) begin
          if (x >= 11'(i * BAR_W)) pix_d = BAR_COLORS[i];
        end
        if (x >= 11'(8 * BAR_W)) pix_d = COL_BLACK;
      end
      PAT_CHECK: pix_d = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
      PAT_GRAD:  pix_d = {x[9:6], y[8:5], frame_cnt_q[5:2]};
      default:   pix_d = in_box ? COL_BOX_FG : COL_BOX_BG;
    endcase
  end

  always_ff @(posedge clk_dot) begin
    if (reset) color_q <= COL_BLACK;
    else       color_q <= vid_active ? pix_d : COL_BLACK;
  end

  assign color       = color_q;
  assign pattern_sel = pat_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_testpattern_gen.sv
module tb_testpattern_gen;

  logic        clk_dot = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = 11'd100;
  logic [9:0]  y = 10'd50;
  logic        vid_active = 1'b0;
  logic        btn_next = 1'b0;
  logic [11:0] color;
  logic [1:0]  pattern_sel;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk_dot = ~clk_dot;

`ifdef TPG_AUTOCYCLE_EN
  testpattern_gen #(.AUTO_FRAMES(4)) dut (
`else
  testpattern_gen dut (
`endif
    .clk_dot     (clk_dot),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .vid_active  (vid_active),
    .btn_next    (btn_next),
    .color       (color),
    .pattern_sel (pattern_sel),
    .frame_cnt   (frame_cnt)
  );

  task automatic tick();
    @(posedge clk_dot);
    #1;
  endtask

  task automatic do_reset();
    x = 11'd100; y = 10'd50; vid_active = 1'b0; btn_next = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // One frame boundary: leave the origin, then land on (0,0) for one cycle.
  task automatic do_frame();
    x = 11'd7; y = 10'd0; tick();
    x = 11'd0; y = 10'd0; tick();
    x = 11'd1;
  endtask

  task automatic press();
    x = 11'd9; y = 10'd3;
    btn_next = 1'b1; tick(); tick();
    btn_next = 1'b0; tick(); tick();
  endtask

  task automatic goto_pattern(input int n);
    do_reset();
    for (int i = 0; i < n; i++) begin
      press();
      do_frame();
    end
  endtask

  task automatic pix(input string name, input int px, input int py, input logic act,
                     input logic [11:0] exp);
    x = 11'(px); y = 10'(py); vid_active = act;
    tick();
    checks++;
    if (color !== exp) begin
      failures++;
      $display("FAIL %s: color=%h expected=%h", name, color, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    press(); do_frame(); do_frame(); do_frame();
    x = 11'd200; y = 10'd40; vid_active = 1'b1; tick();
    do_reset();
    checks++;
    if (color !== 12'h000 || pattern_sel !== 2'd0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: color=%h pat=%0d fcnt=%0d expected 000/0/0",
               color, pattern_sel, frame_cnt);
    end
    checks++;
    if (dut.bx !== 11'd0 || dut.by !== 10'd0) begin
      failures++;
      $display("FAIL reset_box: bx=%0d by=%0d expected 0/0", dut.bx, dut.by);
    end
    tick();
    checks++;
    if (frame_cnt !== 8'd0 || pattern_sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold: fcnt=%0d pat=%0d expected 0/0", frame_cnt, pattern_sel);
    end
  endtask

  task automatic test_bars();
    do_reset();
    pix("bars_x0",   0,   10, 1'b1, 12'hFFF);
    pix("bars_x79",  79,  10, 1'b1, 12'hFFF);
    pix("bars_x80",  80,  10, 1'b1, 12'hFF0);
    pix("bars_x160", 160, 10, 1'b1, 12'h0FF);
    pix("bars_x559", 559, 10, 1'b1, 12'h00F);
    pix("bars_x560", 560, 10, 1'b1, 12'h000);
    pix("bars_x639", 639, 10, 1'b1, 12'h000);
    pix("bars_x700", 700, 10, 1'b1, 12'h000);
    pix("bars_inact", 80, 10, 1'b0, 12'h000);
  endtask

  task automatic test_button();
    do_reset();
    press();
    repeat (5) tick();
    checks++;
    if (pattern_sel !== 2'd0) begin
      failures++;
      $display("FAIL btn_midframe: pat=%0d expected 0", pattern_sel);
    end
    do_frame();
    checks++;
    if (pattern_sel !== 2'd1) begin
      failures++;
      $display("FAIL btn_applied: pat=%0d expected 1", pattern_sel);
    end
    press(); press(); press();
    do_frame();
    checks++;
    if (pattern_sel !== 2'd2) begin
      failures++;
      $display("FAIL btn_triple: pat=%0d expected 2", pattern_sel);
    end
    do_frame();
    checks++;
    if (pattern_sel !== 2'd2) begin
      failures++;
      $display("FAIL btn_idle_frame: pat=%0d expected 2", pattern_sel);
    end
    press(); do_frame();
    press(); do_frame();
    checks++;
    if (pattern_sel !== 2'd0) begin
      failures++;
      $display("FAIL btn_wrap: pat=%0d expected 0", pattern_sel);
    end
    // Edge reaches the detector in the same cycle as frame_start.
    x = 11'd3; y = 10'd0;
    btn_next = 1'b1; tick(); tick();
    x = 11'd0; tick();
    checks++;
    if (pattern_sel !== 2'd1) begin
      failures++;
      $display("FAIL btn_same_cycle: pat=%0d expected 1", pattern_sel);
    end
    btn_next = 1'b0;
    tick(); tick();
    do_frame();
    checks++;
    if (pattern_sel !== 2'd1) begin
      failures++;
      $display("FAIL btn_no_residue: pat=%0d expected 1", pattern_sel);
    end
  endtask

  task automatic test_checker();
    goto_pattern(1);
    pix("chk_31_0",  31, 0,  1'b1, 12'h000);
    pix("chk_32_0",  32, 0,  1'b1, 12'hFFF);
    pix("chk_32_32", 32, 32, 1'b1, 12'h000);
    pix("chk_0_32",  0,  32, 1'b1, 12'hFFF);
  endtask

  task automatic test_gradient();
    goto_pattern(2);
    pix("grad_576_416", 576, 416, 1'b1, 12'h9D0);
    pix("grad_64_32",   64,  32,  1'b1, 12'h110);
    do_frame(); do_frame();
    pix("grad_blue",    64,  32,  1'b1, 12'h111);
  endtask

  task automatic test_box_pattern();
    goto_pattern(3);
    pix("box_in_tl",   3,  3,  1'b1, 12'hF80);
    pix("box_left",    2,  3,  1'b1, 12'h008);
    pix("box_in_br",   34, 34, 1'b1, 12'hF80);
    pix("box_right",   35, 3,  1'b1, 12'h008);
    pix("box_below",   3,  35, 1'b1, 12'h008);
  endtask

  task automatic box_at(input string name, input int ex, input int ey);
    checks++;
    if (dut.bx !== 11'(ex) || dut.by !== 10'(ey)) begin
      failures++;
      $display("FAIL %s: bx=%0d by=%0d expected %0d/%0d", name, dut.bx, dut.by, ex, ey);
    end
  endtask

  task automatic test_box_bounce();
    do_reset();
    vid_active = 1'b0;
    do_frame();
    box_at("box_f1", 1, 1);
    repeat (447) do_frame();
    box_at("box_f448", 448, 448);
    do_frame();
    box_at("box_f449", 449, 447);
    repeat (159) do_frame();
    box_at("box_f608", 608, 288);
    do_frame();
    box_at("box_f609", 607, 287);
    repeat (287) do_frame();
    box_at("box_f896", 320, 0);
    do_frame();
    box_at("box_f897", 319, 1);
    checks++;
    if (frame_cnt !== 8'd129) begin
      failures++;
      $display("FAIL frame_wrap: fcnt=%0d expected 129", frame_cnt);
    end
  endtask

`ifdef TPG_AUTOCYCLE_EN
  task automatic pat_is(input string name, input int ep);
    checks++;
    if (pattern_sel !== 2'(ep)) begin
      failures++;
      $display("FAIL %s: pat=%0d expected %0d", name, pattern_sel, ep);
    end
  endtask

  task automatic test_autocycle();
    do_reset();
    repeat (3) do_frame();
    pat_is("auto_f3", 0);
    do_frame();  pat_is("auto_f4", 1);
    repeat (4) do_frame(); pat_is("auto_f8", 2);
    repeat (4) do_frame(); pat_is("auto_f12", 3);
    repeat (4) do_frame(); pat_is("auto_f16", 0);
    do_reset();
    do_frame();
    press(); do_frame(); pat_is("auto_btn_f2", 1);
    repeat (3) do_frame(); pat_is("auto_btn_f5", 1);
    do_frame(); pat_is("auto_btn_f6", 2);
  endtask
`endif

  initial begin
    test_reset();
    test_bars();
    test_button();
    test_checker();
    test_gradient();
    test_box_pattern();
    test_box_bounce();
`ifdef TPG_AUTOCYCLE_EN
    test_autocycle();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
